// File: rtl/ahb_burst_sequencer.sv
// ahb_burst_sequencer
//   Master-side AHB burst sequencer. Accepts one burst command over a
//   valid/ready handshake and plays it out on the AHB address phase one beat
//   at a time, feeding hwdata in the data phase for writes and capturing
//   hrdata for reads.
//
// Parameters
//   AW    address width
//   DW    data width
//   SELW  width of the hsel slave index
//
// Ports
//   clk, hreset                 clock and synchronous active-high reset
//   cmd_valid / cmd_ready       command handshake (ready only while idle)
//   cmd_addr, cmd_size,
//   cmd_burst, cmd_len,
//   cmd_write, cmd_sel          burst command fields
//   wr_data / wr_valid /
//   wr_ready                    write-data stream, one word per write beat
//   hready, hresp, hrdata       AHB slave response
//   haddr, htrans, hburst,
//   hsize, hwrite, hsel         AHB address phase
//   hwdata                      AHB write data (data phase)
//   rd_data / rd_valid          captured read data, one strobe per read beat
//   done                        one-cycle pulse at the end of a burst
//
// Configuration
//   AHB_ERR_ABORT_EN  when defined, an ERROR response on a completed data
//                     phase aborts the rest of the burst. When undefined,
//                     hresp is ignored and every burst runs to completion.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no burst; htrans=IDLE, cmd_ready=1
// NSEQ  | first beat address phase (NONSEQ, or IDLE while write data missing)
// SEQ   | subsequent beat address phase (SEQ, or BUSY while write data missing)
// LAST  | all addresses issued; waiting out the final data phase

module ahb_burst_sequencer #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            hreset,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [2:0]      cmd_size,
    input  logic [2:0]      cmd_burst,
    input  logic [3:0]      cmd_len,
    input  logic            cmd_write,
    input  logic [SELW-1:0] cmd_sel,

    input  logic [DW-1:0]   wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,

    input  logic            hready,
    input  logic            hresp,
    input  logic [DW-1:0]   hrdata,

    output logic [AW-1:0]   haddr,
    output logic [1:0]      htrans,
    output logic [2:0]      hburst,
    output logic [2:0]      hsize,
    output logic            hwrite,
    output logic [SELW-1:0] hsel,
    output logic [DW-1:0]   hwdata,

    output logic [DW-1:0]   rd_data,
    output logic            rd_valid,
    output logic            done
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;
    localparam logic [2:0] HB_WRAP4  = 3'b010;
    localparam logic [2:0] HB_INCR4  = 3'b011;
    localparam logic [2:0] HB_WRAP8  = 3'b100;
    localparam logic [2:0] HB_INCR8  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NSEQ,
        ST_SEQ,
        ST_LAST
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]    beat_cnt;
    logic [3:0]    beats_m1;
    logic          dp_valid;
    logic          dp_write;

    logic [AW-1:0] step_bytes;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] addr_incr;
    logic [AW-1:0] addr_next;
    logic          is_wrap;
    logic          wr_stall;
    logic          data_done;
    logic          abort;
    logic          accept;
    logic          last_beat;
    logic          in_addr_phase;

    // Beat count minus one; undefined burst encodings fall back to a single beat.
    function automatic logic [3:0] decode_beats_m1(input logic [2:0] burst,
                                                   input logic [3:0] len);
        logic [3:0] n;
        case (burst)
            HB_SINGLE:          n = 4'd0;
            HB_INCR:            n = len;
            HB_WRAP4, HB_INCR4: n = 4'd3;
            HB_WRAP8, HB_INCR8: n = 4'd7;
            default:            n = 4'd0;
        endcase
        return n;
    endfunction

    // Address stepping. The wrap boundary is beats*bytes, which is always a
    // power of two, so the low bits wrap and the high bits stay put.
    always_comb begin
        is_wrap    = (hburst == HB_WRAP4) || (hburst == HB_WRAP8);
        step_bytes = AW'(1) << hsize;
        wrap_mask  = ((hburst == HB_WRAP8) ? (AW'(8) << hsize)
                                           : (AW'(4) << hsize)) - AW'(1);
        addr_incr  = haddr + step_bytes;
        addr_next  = is_wrap ? ((haddr & ~wrap_mask) | (addr_incr & wrap_mask))
                             : addr_incr;
    end

    assign in_addr_phase = (state == ST_NSEQ) || (state == ST_SEQ);
    assign wr_stall      = hwrite && !wr_valid;
    assign data_done     = dp_valid && hready;
    assign last_beat     = (beat_cnt == beats_m1);

`ifdef AHB_ERR_ABORT_EN
    assign abort = data_done && hresp;
`else
    logic unused_hresp;
    assign unused_hresp = hresp;
    assign abort        = 1'b0;
`endif

    // An address offered in the same cycle as an aborting error response is
    // dropped along with the rest of the burst.
    assign accept = in_addr_phase && !wr_stall && hready && !abort;

    always_comb begin
        state_nxt = state;
        htrans    = HT_IDLE;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = ST_NSEQ;
                end
            end
            ST_NSEQ: begin
                // Without write data the first beat is simply not started yet.
                htrans = wr_stall ? HT_IDLE : HT_NONSEQ;
                if (accept) begin
                    state_nxt = last_beat ? ST_LAST : ST_SEQ;
                end
            end
            ST_SEQ: begin
                htrans = wr_stall ? HT_BUSY : HT_SEQ;
                if (accept) begin
                    state_nxt = last_beat ? ST_LAST : ST_SEQ;
                end
            end
            ST_LAST: begin
                if (hready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_nxt = ST_IDLE;
        end

        wr_ready = accept && hwrite;
    end

    always_ff @(posedge clk) begin
        if (hreset) begin
            state    <= ST_IDLE;
            haddr    <= '0;
            hburst   <= '0;
            hsize    <= '0;
            hwrite   <= 1'b0;
            hsel     <= '0;
            hwdata   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            beat_cnt <= '0;
            beats_m1 <= '0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
        end else begin
            state <= state_nxt;

            if ((state == ST_IDLE) && cmd_valid) begin
                haddr    <= cmd_addr;
                hburst   <= cmd_burst;
                hsize    <= cmd_size;
                hwrite   <= cmd_write;
                hsel     <= cmd_sel;
                beats_m1 <= decode_beats_m1(cmd_burst, cmd_len);
                beat_cnt <= '0;
            end else if (accept && !last_beat) begin
                haddr    <= addr_next;
                beat_cnt <= beat_cnt + 4'd1;
            end

            // A data phase lasts from the accepting edge until the next
            // hready; a stalled cycle keeps whatever phase is in flight.
            if (hready) begin
                dp_valid <= accept;
                dp_write <= hwrite;
            end

            if (wr_ready) begin
                hwdata <= wr_data;
            end

            rd_valid <= data_done && !dp_write;
            if (data_done && !dp_write) begin
                rd_data <= hrdata;
            end

            done <= ((state == ST_LAST) && hready) || abort;
        end
    end

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
module tb_ahb_burst_sequencer;

    logic        clk;
    logic        hreset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [2:0]  cmd_burst;
    logic [3:0]  cmd_len;
    logic        cmd_write;
    logic [1:0]  cmd_sel;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [1:0]  hsel;
    logic [31:0] hwdata;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;

    ahb_burst_sequencer #(.AW(32), .DW(32), .SELW(2)) dut (
        .clk       (clk),
        .hreset    (hreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_burst (cmd_burst),
        .cmd_len   (cmd_len),
        .cmd_write (cmd_write),
        .cmd_sel   (cmd_sel),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .haddr     (haddr),
        .htrans    (htrans),
        .hburst    (hburst),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .hsel      (hsel),
        .hwdata    (hwdata),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done)
    );

    int vectors     = 0;
    int miscompares = 0;

    // stimulus windows, in cycles counted from command acceptance (cycle 0)
    int hr_lo_s = 0;
    int hr_lo_n = 0;
    int wv_lo_s = 0;
    int wv_lo_n = 0;
    int err_cyc = -1;
    logic [31:0] wd_base = 32'h0;
    logic [31:0] rd_base = 32'h0;

    // monitor state
    int cyc       = 1000;
    int wr_idx    = 0;
    int rd_idx    = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int busy_cnt  = 0;
    logic wdp     = 1'b0;
    logic rdp     = 1'b0;
    logic [31:0] acc_addr [$];
    logic [31:0] wd_q     [$];
    logic [31:0] rd_q     [$];
    logic [31:0] exp_q    [$];
    logic [31:0] haddr_at  [0:31];
    logic [1:0]  htrans_at [0:31];
    logic [31:0] hwdata_at [0:31];
    logic [31:0] ctl_at    [0:31];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int sel);
        int n;
        logic [31:0] got;
        n = (sel == 0) ? acc_addr.size() : (sel == 1) ? wd_q.size() : rd_q.size();
        chk({tag, "_len"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            got = (sel == 0) ? acc_addr[i] : (sel == 1) ? wd_q[i] : rd_q[i];
            chk($sformatf("%s[%0d]", tag, i), got, exp_q[i]);
        end
    endtask

    // slave / write-data source: inputs change 1 time unit after the edge
    initial begin
        hready   = 1'b1;
        hresp    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 32'h0;
        hrdata   = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            hready   = !((cyc + 1) >= hr_lo_s && (cyc + 1) < hr_lo_s + hr_lo_n);
            wr_valid = !((cyc + 1) >= wv_lo_s && (cyc + 1) < wv_lo_s + wv_lo_n);
            hresp    = ((cyc + 1) == err_cyc);
            wr_data  = wd_base + 32'(wr_idx);
            hrdata   = rd_base + 32'(rd_idx);
        end
    end

    // bus monitor, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                cyc = 0;
                acc_addr.delete();
                wd_q.delete();
                rd_q.delete();
                wr_idx   = 0;
                rd_idx   = 0;
                done_cnt = 0;
                done_cyc = -1;
                busy_cnt = 0;
                wdp      = 1'b0;
                rdp      = 1'b0;
            end else begin
                cyc++;
            end
            if (cyc >= 0 && cyc < 32) begin
                haddr_at[cyc]  = haddr;
                htrans_at[cyc] = htrans;
                hwdata_at[cyc] = hwdata;
                ctl_at[cyc]    = {23'd0, hsel, hburst, hsize, hwrite};
            end
            if (htrans[1] && hready) acc_addr.push_back(haddr);
            if (htrans == 2'b01) busy_cnt++;
            if (rd_valid) rd_q.push_back(rd_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (wr_ready) wr_idx++;
            if (wdp && hready) wd_q.push_back(hwdata);
            if (rdp && hready) rd_idx++;
            if (hreset) begin
                wdp = 1'b0;
                rdp = 1'b0;
            end else if (hready) begin
                wdp = htrans[1] && hwrite;
                rdp = htrans[1] && !hwrite;
            end
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [2:0] sz, input logic [2:0] bu,
                           input logic [3:0] ln, input logic wr, input logic [1:0] sel);
        @(posedge clk);
        #1;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_burst = bu;
        cmd_len   = ln;
        cmd_write = wr;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        sample();
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 60) begin
            sample();
            n++;
        end
        chk("done_seen", {31'd0, done_cnt != 0}, 32'd1);
        repeat (4) sample();
        chk("done_once", 32'(done_cnt), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_htrans"},   {30'd0, htrans}, 32'd0);
        chk({tag, "_haddr"},    haddr, 32'd0);
        chk({tag, "_ctl"},      {23'd0, hsel, hburst, hsize, hwrite}, 32'd0);
        chk({tag, "_hwdata"},   hwdata, 32'd0);
        chk({tag, "_rd_data"},  rd_data, 32'd0);
        chk({tag, "_flags"},    {28'd0, rd_valid, done, wr_ready, cmd_ready}, 32'h1);
    endtask

    initial begin
        hreset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        cmd_size  = 3'd0;
        cmd_burst = 3'd0;
        cmd_len   = 4'd0;
        cmd_write = 1'b0;
        cmd_sel   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        hreset = 1'b0;
        sample();
        chk_reset_outputs("rst");

        // WRAP4 write, 0x34, word size, data 1..4
        wd_base = 32'h1;
        run_cmd(32'h34, 3'd2, 3'b010, 4'd0, 1'b1, 2'd1);
        wait_done();
        exp_q = '{32'h34, 32'h38, 32'h3C, 32'h30};
        chk_q("wrap4_addr", 0);
        exp_q = '{32'h1, 32'h2, 32'h3, 32'h4};
        chk_q("wrap4_wdata", 1);
        chk("wrap4_done_cyc", 32'(done_cyc), 32'd6);
        chk("wrap4_trans", {24'd0, htrans_at[1], htrans_at[2], htrans_at[3], htrans_at[4]}, 32'hBF);
        chk("wrap4_trans_last", {30'd0, htrans_at[5]}, 32'd0);
        chk("wrap4_ctl", ctl_at[1], 32'hA5);

        // INCR4 read, byte size; a competing command mid-burst must be ignored
        rd_base = 32'hA0;
        run_cmd(32'h10, 3'd0, 3'b011, 4'd0, 1'b0, 2'd0);
        cmd_addr  = 32'hDEAD0;
        cmd_valid = 1'b1;
        sample();
        chk("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done();
        exp_q = '{32'h10, 32'h11, 32'h12, 32'h13};
        chk_q("incr4_addr", 0);
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        chk_q("incr4_rdata", 2);
        chk("incr4_done_cyc", 32'(done_cyc), 32'd6);

        // WRAP8 write, 0x1C, wr_valid low for two cycles at beat 3
        wd_base = 32'h100;
        wv_lo_s = 4;
        wv_lo_n = 2;
        run_cmd(32'h1C, 3'd2, 3'b100, 4'd0, 1'b1, 2'd0);
        wait_done();
        wv_lo_n = 0;
        exp_q = '{32'h1C, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
        chk_q("wrap8_addr", 0);
        exp_q = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107};
        chk_q("wrap8_wdata", 1);
        chk("wrap8_busy_cnt", 32'(busy_cnt), 32'd2);
        chk("wrap8_busy_trans", {30'd0, htrans_at[5]}, 32'd1);
        chk("wrap8_busy_addr", haddr_at[5], 32'h08);
        chk("wrap8_done_cyc", 32'(done_cyc), 32'd12);

        // INCR len=2 write, 0x100, hready low 3 cycles on beat 1
        wd_base = 32'h55000;
        hr_lo_s = 2;
        hr_lo_n = 3;
        run_cmd(32'h100, 3'd2, 3'b001, 4'd2, 1'b1, 2'd2);
        wait_done();
        hr_lo_n = 0;
        exp_q = '{32'h100, 32'h104, 32'h108};
        chk_q("incr_addr", 0);
        exp_q = '{32'h55000, 32'h55001, 32'h55002};
        chk_q("incr_wdata", 1);
        chk("incr_stall_addr", haddr_at[4], 32'h104);
        chk("incr_stall_hwdata", hwdata_at[4], 32'h55000);
        chk("incr_stall_trans", {30'd0, htrans_at[4]}, 32'd3);
        chk("incr_done_cyc", 32'(done_cyc), 32'd8);

        // INCR8 read, ERROR on the data phase of beat 2
        rd_base = 32'h50000000;
        err_cyc = 4;
        run_cmd(32'h200, 3'd2, 3'b101, 4'd0, 1'b0, 2'd0);
        wait_done();
        err_cyc = -1;
`ifdef AHB_ERR_ABORT_EN
        exp_q = '{32'h50000000, 32'h50000001, 32'h50000002};
        chk_q("err_rdata", 2);
        chk("err_done_cyc", 32'(done_cyc), 32'd5);
        chk("err_trans_after", {30'd0, htrans_at[5]}, 32'd0);
`else
        exp_q = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h218, 32'h21C};
        chk_q("err_addr", 0);
        exp_q = '{32'h50000000, 32'h50000001, 32'h50000002, 32'h50000003,
                  32'h50000004, 32'h50000005, 32'h50000006, 32'h50000007};
        chk_q("err_rdata", 2);
        chk("err_done_cyc", 32'(done_cyc), 32'd10);
        chk("err_trans_after", {30'd0, htrans_at[5]}, 32'd3);
`endif

        // reset during beat 2 of a WRAP4 write
        wd_base = 32'h77;
        run_cmd(32'h34, 3'd2, 3'b010, 4'd0, 1'b1, 2'd3);
        begin
            int n;
            n = 0;
            while (cyc < 2 && n < 20) begin
                sample();
                n++;
            end
        end
        chk("rst_mid_pre_addr", haddr, 32'h38);
        @(posedge clk);
        #1;
        hreset = 1'b1;
        @(posedge clk);
        #1;
        hreset = 1'b0;
        sample();
        chk_reset_outputs("rst_mid");
        repeat (6) sample();
        chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
        chk("rst_mid_idle", {30'd0, htrans}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
